// File: rtl/bit32_serial_subtractor.sv
// Multi-cycle 32-bit subtractor: d = a - b - bin, one SLICE_W-bit slice per clock.
// Optional SUB_ADD_MODE_EN adds add_sel to compute d = a + b + bin on the same datapath.
module bit32_serial_subtractor #(
    parameter int unsigned SLICE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
`ifdef SUB_ADD_MODE_EN
    input  logic        add_sel,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] d,
    output logic        bout,
    output logic        zero,
    output logic        neg,
    output logic        ovf
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NSLICES = DATA_W / SLICE_W;
    localparam int unsigned CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                brw_q, brw_d;
    logic                add_q, add_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic                bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

    logic [4:0]          lo;
    logic [SLICE_W-1:0]  a_sl, b_sl;
    logic [SLICE_W:0]    sl_res;

    // Slice datapath; in add mode b is inverted and the borrow carries inverted carry.
    always_comb begin
        lo     = 5'(32'(cnt_q) * SLICE_W);
        a_sl   = a_q[lo +: SLICE_W];
        b_sl   = b_q[lo +: SLICE_W] ^ {SLICE_W{add_q}};
        sl_res = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE_W{1'b0}}, brw_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        add_d   = add_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
`ifdef SUB_ADD_MODE_EN
                    add_d = add_sel;
`else
                    add_d = 1'b0;
`endif
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin ^ add_d;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                busy_d               = 1'b1;
                res_d[lo +: SLICE_W] = sl_res[SLICE_W-1:0];
                brw_d                = sl_res[SLICE_W];
                cnt_d                = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSLICES - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    d_d     = res_d;
                    bout_d  = sl_res[SLICE_W] ^ add_q;
                    zero_d  = (res_d == '0);
                    neg_d   = res_d[DATA_W-1];
                    ovf_d   = ((a_q[DATA_W-1] ^ b_q[DATA_W-1]) ^ add_q) &&
                              (res_d[DATA_W-1] != a_q[DATA_W-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            add_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            add_q   <= add_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit32_serial_subtractor.sv
// Self-checking bench for bit32_serial_subtractor (SLICE_W=8) against an arithmetic model.
module tb_bit32_serial_subtractor;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        add_sel = 1'b0;
    logic        busy, done, bout, zero, neg, ovf;
    logic [31:0] d;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] prev_d = '0;

    bit32_serial_subtractor #(.SLICE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
`ifdef SUB_ADD_MODE_EN
        .add_sel(add_sel),
`endif
        .busy(busy), .done(done), .d(d), .bout(bout),
        .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] aa, input logic [31:0] bb, input logic bi,
                          input logic ad);
        a = aa; b = bb; bin = bi; add_sel = ad; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the current point until done; lat=0 means it never came.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                            input logic bi, input logic ad);
        logic [32:0] r;
        logic [31:0] ed;
        logic        eb, ez, en, eo;
        int          lat, bcnt;
        if (ad) r = {1'b0, aa} + {1'b0, bb} + 33'(bi);
        else    r = {1'b0, aa} - {1'b0, bb} - 33'(bi);
        ed = r[31:0];
        eb = r[32];
        ez = (ed == 32'd0);
        en = ed[31];
        eo = ad ? ((aa[31] == bb[31]) && (ed[31] != aa[31]))
                : ((aa[31] != bb[31]) && (ed[31] != aa[31]));
        launch(aa, bb, bi, ad);
        check({tag, "_hold"}, 64'(d), 64'(prev_d));
        wait_done(lat, bcnt);
        check({tag, "_lat"}, 64'(lat), 64'(NS));
        check({tag, "_busy"}, 64'(bcnt), 64'(NS));
        check({tag, "_d"}, 64'(d), 64'(ed));
        check({tag, "_flags"}, 64'({bout, zero, neg, ovf}), 64'({eb, ez, en, eo}));
        prev_d = ed;
    endtask

    initial begin
        int lat, bcnt, saw;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 64'({busy, done, d, bout, zero, neg, ovf}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic subtract with explicit expected values
        op_check("t1", 32'd10, 32'd3, 1'b0, 1'b0);
        check("t1_lit", 64'({d, bout, zero, neg, ovf}), 64'({32'd7, 4'b0000}));
        @(posedge clk); #1;
        check("t1_done_pulse", 64'({done, busy}), 64'd0);

        op_check("t2a", 32'h0, 32'h1, 1'b0, 1'b0);
        check("t2a_lit", 64'({d, bout, neg, ovf}), 64'({32'hFFFF_FFFF, 3'b110}));
        op_check("t2b", 32'h100, 32'h1, 1'b0, 1'b0);
        check("t2b_lit", 64'(d), 64'h0000_00FF);

        op_check("t3a", 32'h8000_0000, 32'h1, 1'b0, 1'b0);
        check("t3a_lit", 64'({d, bout, neg, ovf}), 64'({32'h7FFF_FFFF, 3'b001}));
        op_check("t3b", 32'd5, 32'd5, 1'b0, 1'b0);
        check("t3b_zero", 64'({d, zero}), 64'({32'd0, 1'b1}));
        op_check("t3c", 32'd5, 32'd4, 1'b1, 1'b0);
        check("t3c_zero", 64'({d, zero}), 64'({32'd0, 1'b1}));
        @(posedge clk); #1;

        // Start during RUN is ignored; start in DONE is taken back-to-back
        launch(32'd20, 32'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("t4a_lat", 64'(lat), 64'(NS - 2));
        check("t4a_d", 64'(d), 64'd19);
        prev_d = 32'd19;
        op_check("t4b", 32'd9, 32'd2, 1'b0, 1'b0);
        check("t4b_lit", 64'(d), 64'd7);

        // Reset mid-operation
        launch(32'hFFFF_0000, 32'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_abort", 64'({busy, done, d, bout, zero, neg, ovf}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1;
        end
        check("t5_no_done", 64'(saw), 64'd0);
        prev_d = 32'd0;
        op_check("t5_fresh", 32'hFFFF_0000, 32'd1, 1'b0, 1'b0);

`ifdef SUB_ADD_MODE_EN
        op_check("t6a", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("t6a_lit", 64'({d, bout, zero, ovf}), 64'({32'd0, 3'b110}));
        op_check("t6b", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("t6b_lit", 64'({d, neg, ovf}), 64'({32'h8000_0000, 2'b11}));
`endif

        // Randomised operations, with occasional idle gaps
        for (int i = 0; i < 40; i++) begin
            logic ad;
`ifdef SUB_ADD_MODE_EN
            ad = 1'($urandom_range(0, 1));
`else
            ad = 1'b0;
`endif
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            op_check("rnd", $urandom, $urandom, 1'($urandom_range(0, 1)), ad);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bit32_serial_subtractor.md
Name: bit32_serial_subtractor

Overview:
- Multi-cycle 32-bit subtractor: computes d = a − b − bin one SLICE_W-bit slice per clock, propagating the borrow between cycles.
- Companion to the combinational 32-bit ripple adder in the ALU datapath. Serves the SUB/SUBU/SLT/SLTU/BEQ-compare paths where area matters more than latency.
- Start/done handshake; registered result and status flags.

Parameters:
SLICE_W, 8, bits processed per cycle; must divide 32 (legal: 1, 2, 4, 8, 16, 32)
NSLICES, 32/SLICE_W, derived localparam (not overridable); cycles per operation

Ports:
clk    input   1   clock, rising edge
rst    input   1   asynchronous reset, active-high
start  input   1   request; sampled when idle or done
a      input   32  minuend, latched on accepted start
b      input   32  subtrahend, latched on accepted start
bin    input   1   borrow in, latched on accepted start
busy   output  1   high while slices are being computed
done   output  1   one-cycle pulse: result valid
d      output  32  difference, registered
bout   output  1   borrow out of bit 31 (1 = unsigned a < b+bin)
zero   output  1   d == 0
neg    output  1   d[31]
ovf    output  1   signed overflow: (a[31] != b[31]) && (d[31] != a[31])

Behaviour:
- Reset (async, rst=1): state=IDLE, slice counter=0, internal borrow=0, busy=0, done=0, d=0, bout=0, zero=0, neg=0, ovf=0.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start=1 at edge E0 in IDLE or DONE → latch a, b, bin; counter=0; →RUN.
  - start while RUN is ignored; the latched operands are not disturbed.
- RUN, edges E1..EN (N = NSLICES):
  - Slice k = counter computes {brw, diff_k} = a_k − b_k − borrow_reg in SLICE_W+1 bits.
  - diff_k is written into the internal result register at bits [k·SLICE_W +: SLICE_W].
  - borrow_reg ← brw; counter increments.
  - At EN (counter = N−1): outputs d, bout, zero, neg, ovf are updated together from the full result; →DONE.
- DONE: done=1 for exactly one cycle, then →IDLE at the next edge, or →RUN if start=1 on that edge (back-to-back).
- busy=1 in RUN only.
- Latency: start sampled at E0 → done high in the cycle after EN, i.e. N cycles after the start edge (4 cycles for SLICE_W=8). Throughput: one operation per N+1 cycles.
- Output hold: visible outputs change only at operation completion; they hold the previous result through the next RUN. Partial slices are never visible on d.
- Arithmetic: modulo 2^32. Flags are computed from the latched a, b and the final d. bin participates only in slice 0.
- Reset mid-operation: aborts immediately. No done pulse; all outputs return to their reset values.
- SLICE_W=32: single RUN cycle; same handshake applies.

Optional Feature:
SUB_ADD_MODE_EN
- Defined:
  - Adds input port add_sel (1 bit), latched with the operands.
  - add_sel=1 computes d = a + b + bin and reuses the slice datapath with the b-slice inverted and the carry sense flipped.
  - bout then reports carry out of bit 31.
  - ovf becomes (a[31] == b[31]) && (d[31] != a[31]).
  - add_sel=0 behaves exactly as the base block.
- Undefined: no add_sel port; subtract only. Logic is identical to the base description.

Test Plan:
1. a=10, b=3, bin=0, start pulse → done exactly 4 cycles after the start edge; d=0x00000007, bout=0, zero=0, neg=0, ovf=0; busy high for 4 cycles.
2. a=0x00000000, b=0x00000001 → d=0xFFFFFFFF, bout=1, neg=1, ovf=0. Then a=0x00000100, b=0x00000001 → d=0x000000FF, checking borrow across the slice-0/1 boundary.
3. a=0x80000000, b=0x00000001 → d=0x7FFFFFFF, ovf=1, bout=0, neg=0. Then a=5, b=5, bin=0 → d=0, zero=1. Then a=5, b=4, bin=1 → d=0, zero=1.
4. Start at E0 with a=20, b=1; at E2 (mid-RUN) pulse start again with a=1, b=1 → second request ignored; done gives d=19. Start asserted in the DONE cycle with a=9, b=2 → accepted back-to-back; second done 4 cycles later with d=7.
5. Start a=0xFFFF0000, b=1; assert rst after 2 RUN cycles → no done; d=0, flags=0, busy=0 immediately. A fresh operation after reset completes normally.
6. With SUB_ADD_MODE_EN: add_sel=1, a=0xFFFFFFFF, b=1, bin=0 → d=0, bout(carry)=1, zero=1, ovf=0. Then a=0x7FFFFFFF, b=1 → d=0x80000000, ovf=1, neg=1.
